// File: rtl/iter_muldiv.sv
//------------------------------------------------------------------------------
// Module      : iter_muldiv
// Description : Radix-2 iterative multiply/divide unit (shift-add multiply,
//               restoring divide) writing one result to the register file.
//               Optional macro MULDIV_SIGNED_EN adds two's-complement support.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iter_muldiv #(
  parameter int SIZE = 32,
  parameter int ADDR = 4
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            Start,
  input  logic [2:1]      Op,
  input  logic            Sgn,
  input  logic [SIZE:1]   A,
  input  logic [SIZE:1]   B,
  input  logic [ADDR:1]   Dst_Addr,
  output logic            Busy,
  output logic            Done,
  output logic            Div_Zero,
  output logic            Write_Reg,
  output logic [ADDR:1]   W_Addr,
  output logic [SIZE:1]   W_Data
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(SIZE);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [2*SIZE:1] r_acc;
  logic [SIZE:1]   r_opnd;
  logic [2:1]      r_op;
  logic [ADDR:1]   r_dst;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_last;
  logic [SIZE:1]   w_mag_a, w_mag_b;
  logic [SIZE:1]   w_hi, w_lo;
  logic [SIZE+1:1] w_sum, w_rem_sh, w_diff;
  logic [2*SIZE:1] w_acc_nxt, w_res;

  // Operand conditioning: magnitudes at accept, sign fix-up on the final value
`ifdef MULDIV_SIGNED_EN
  logic w_neg_a, w_neg_b;
  logic r_neg_lo, r_neg_hi;

  assign w_neg_a = Sgn & A[SIZE];
  assign w_neg_b = Sgn & B[SIZE];
  assign w_mag_a = w_neg_a ? -A : A;
  assign w_mag_b = w_neg_b ? -B : B;

  always_comb begin
    w_res = w_acc_nxt;
    if (!r_op[2]) begin
      if (r_neg_lo) w_res = -w_acc_nxt;
    end else begin
      if (r_neg_hi) w_res[2*SIZE:SIZE+1] = -w_acc_nxt[2*SIZE:SIZE+1];
      if (r_neg_lo) w_res[SIZE:1]        = -w_acc_nxt[SIZE:1];
    end
  end
`else
  logic w_unused_sgn;

  assign w_unused_sgn = Sgn;
  assign w_mag_a      = A;
  assign w_mag_b      = B;
  assign w_res        = w_acc_nxt;
`endif

  assign w_accept = Start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last   = (r_cnt == C_CNT_ONE);
  assign Busy     = (r_state == S_RUN);
  assign Done     = (r_state == S_DONE);
  assign Write_Reg = Done;

  // One radix-2 step; multiply keeps its carry in the top sum bit before the shift
  always_comb begin
    w_hi     = r_acc[2*SIZE:SIZE+1];
    w_lo     = r_acc[SIZE:1];
    w_sum    = {1'b0, w_hi} + (w_lo[1] ? {1'b0, r_opnd} : '0);
    w_rem_sh = r_acc[2*SIZE:SIZE];
    w_diff   = w_rem_sh - {1'b0, r_opnd};
    if (!r_op[2])
      w_acc_nxt = {w_sum, w_lo[SIZE:2]};
    else if (w_diff[SIZE+1])
      w_acc_nxt = {w_rem_sh[SIZE:1], w_lo[SIZE-1:1], 1'b0};
    else
      w_acc_nxt = {w_diff[SIZE:1], w_lo[SIZE-1:1], 1'b1};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_op     <= '0;
      r_dst    <= '0;
      r_cnt    <= '0;
      W_Data   <= '0;
      W_Addr   <= '0;
      Div_Zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
`endif
    end else if (w_accept) begin
      r_op  <= Op;
      r_dst <= Dst_Addr;
      r_cnt <= C_CNT_LOAD;
      if (!Op[2]) begin
        r_opnd <= w_mag_a;
        r_acc  <= {{SIZE{1'b0}}, w_mag_b};
      end else begin
        r_opnd <= w_mag_b;
        r_acc  <= {{SIZE{1'b0}}, w_mag_a};
      end
`ifdef MULDIV_SIGNED_EN
      // A zero divisor leaves the all-ones quotient untouched
      r_neg_hi <= Op[2] ? w_neg_a : (w_neg_a ^ w_neg_b);
      r_neg_lo <= (w_neg_a ^ w_neg_b) & (!Op[2] | (B != '0));
`endif
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt - C_CNT_ONE;
      if (w_last) begin
        W_Data   <= r_op[1] ? w_res[2*SIZE:SIZE+1] : w_res[SIZE:1];
        W_Addr   <= r_dst;
        Div_Zero <= r_op[2] & (r_opnd == '0);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iter_muldiv.sv
//------------------------------------------------------------------------------
// Module      : tb_iter_muldiv
// Description : Directed self-checking bench for iter_muldiv (SIZE=32).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iter_muldiv;

  localparam int SIZE = 32;
  localparam int ADDR = 4;

  logic            Clk = 1'b0;
  logic            Clr;
  logic            Start;
  logic [2:1]      Op;
  logic            Sgn;
  logic [SIZE:1]   A, B;
  logic [ADDR:1]   Dst_Addr;
  logic            Busy, Done, Div_Zero, Write_Reg;
  logic [ADDR:1]   W_Addr;
  logic [SIZE:1]   W_Data;

  int checks   = 0;
  int failures = 0;

  iter_muldiv #(.SIZE(SIZE), .ADDR(ADDR)) dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .Op(Op), .Sgn(Sgn),
    .A(A), .B(B), .Dst_Addr(Dst_Addr),
    .Busy(Busy), .Done(Done), .Div_Zero(Div_Zero), .Write_Reg(Write_Reg),
    .W_Addr(W_Addr), .W_Data(W_Data)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request; the next rising edge accepts it
  task automatic issue(input logic [2:1] op, input logic sgn, input logic [SIZE:1] a,
                       input logic [SIZE:1] b, input logic [ADDR:1] dst);
    Start = 1'b1; Op = op; Sgn = sgn; A = a; B = b; Dst_Addr = dst;
  endtask

  // Count edges (accepting edge first) until Done is seen; operands are scrambled after accept
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles = -1;
    busy_cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge Clk); #1;
      if (n == 1) begin
        Start = 1'b0; A = 32'hDEADBEEF; B = 32'h12345678; Dst_Addr = 4'hF;
      end
      if (Busy) busy_cnt++;
      if (Done) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic idle_edge();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Clr = 1'b1; Start = 1'b0; Op = 2'b00; Sgn = 1'b0; A = '0; B = '0; Dst_Addr = '0;
    repeat (3) @(posedge Clk);
    #1;
    checks += 6;
    if (Busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    if (Done !== 1'b0)      begin failures++; $display("FAIL reset_done: got %b expected 0", Done); end
    if (Div_Zero !== 1'b0)  begin failures++; $display("FAIL reset_divzero: got %b expected 0", Div_Zero); end
    if (Write_Reg !== 1'b0) begin failures++; $display("FAIL reset_write: got %b expected 0", Write_Reg); end
    if (W_Addr !== 4'h0)    begin failures++; $display("FAIL reset_waddr: got %h expected 0", W_Addr); end
    if (W_Data !== 32'h0)   begin failures++; $display("FAIL reset_wdata: got %h expected 0", W_Data); end
    Clr = 1'b0;
    idle_edge();
  endtask

  task automatic test_mullo();
    int c, bc;
    issue(2'b00, 1'b0, 32'd7, 32'd6, 4'd3);
    wait_done(c, bc);
    checks += 6;
    if (c !== 33)           begin failures++; $display("FAIL mullo_latency: got %0d expected 33", c); end
    if (bc !== 32)          begin failures++; $display("FAIL mullo_busy_cycles: got %0d expected 32", bc); end
    if (Write_Reg !== 1'b1) begin failures++; $display("FAIL mullo_write: got %b expected 1", Write_Reg); end
    if (W_Addr !== 4'd3)    begin failures++; $display("FAIL mullo_waddr: got %h expected 3", W_Addr); end
    if (W_Data !== 32'd42)  begin failures++; $display("FAIL mullo_wdata: got %h expected 2a", W_Data); end
    if (Div_Zero !== 1'b0)  begin failures++; $display("FAIL mullo_divzero: got %b expected 0", Div_Zero); end
    idle_edge();
    checks += 3;
    if (Done !== 1'b0)      begin failures++; $display("FAIL mullo_done_pulse: got %b expected 0", Done); end
    if (Write_Reg !== 1'b0) begin failures++; $display("FAIL mullo_write_pulse: got %b expected 0", Write_Reg); end
    if (W_Data !== 32'd42)  begin failures++; $display("FAIL mullo_wdata_hold: got %h expected 2a", W_Data); end
  endtask

  task automatic test_back_to_back();
    int c, bc;
    issue(2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5);
    wait_done(c, bc);
    checks += 3;
    if (c !== 33)                 begin failures++; $display("FAIL b2b_first_latency: got %0d expected 33", c); end
    if (W_Data !== 32'hFFFFFFFE)  begin failures++; $display("FAIL b2b_mulhi: got %h expected fffffffe", W_Data); end
    if (W_Addr !== 4'd5)          begin failures++; $display("FAIL b2b_waddr1: got %h expected 5", W_Addr); end
    issue(2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6);
    wait_done(c, bc);
    checks += 3;
    if (c !== 33)                 begin failures++; $display("FAIL b2b_spacing: got %0d expected 33", c); end
    if (W_Data !== 32'h00000001)  begin failures++; $display("FAIL b2b_mullo: got %h expected 00000001", W_Data); end
    if (W_Addr !== 4'd6)          begin failures++; $display("FAIL b2b_waddr2: got %h expected 6", W_Addr); end
    idle_edge();
  endtask

  task automatic test_div_zero();
    int c, bc;
    issue(2'b10, 1'b0, 32'd5, 32'd0, 4'd0);
    wait_done(c, bc);
    checks += 3;
    if (W_Data !== 32'hFFFFFFFF) begin failures++; $display("FAIL dz_quot: got %h expected ffffffff", W_Data); end
    if (Div_Zero !== 1'b1)       begin failures++; $display("FAIL dz_flag_q: got %b expected 1", Div_Zero); end
    if (W_Addr !== 4'd0)         begin failures++; $display("FAIL dz_waddr0: got %h expected 0", W_Addr); end
    idle_edge();
    issue(2'b11, 1'b0, 32'd5, 32'd0, 4'd1);
    wait_done(c, bc);
    checks += 2;
    if (W_Data !== 32'd5)        begin failures++; $display("FAIL dz_rem: got %h expected 5", W_Data); end
    if (Div_Zero !== 1'b1)       begin failures++; $display("FAIL dz_flag_r: got %b expected 1", Div_Zero); end
    idle_edge();
  endtask

  task automatic test_div();
    int c, bc;
    issue(2'b10, 1'b0, 32'd100, 32'd7, 4'd2);
    wait_done(c, bc);
    checks += 3;
    if (c !== 33)            begin failures++; $display("FAIL divq_latency: got %0d expected 33", c); end
    if (W_Data !== 32'd14)   begin failures++; $display("FAIL divq: got %h expected e", W_Data); end
    if (Div_Zero !== 1'b0)   begin failures++; $display("FAIL divq_divzero: got %b expected 0", Div_Zero); end
    idle_edge();
    issue(2'b11, 1'b0, 32'd100, 32'd7, 4'd4);
    wait_done(c, bc);
    checks += 2;
    if (W_Data !== 32'd2)    begin failures++; $display("FAIL divr: got %h expected 2", W_Data); end
    if (Div_Zero !== 1'b0)   begin failures++; $display("FAIL divr_divzero: got %b expected 0", Div_Zero); end
    idle_edge();
  endtask

  task automatic test_clr_abort();
    int seen;
    issue(2'b00, 1'b0, 32'd7, 32'd6, 4'd9);
    for (int n = 1; n <= 10; n++) begin
      @(posedge Clk); #1;
      if (n == 1) Start = 1'b0;
    end
    #2 Clr = 1'b1;
    #1;
    checks += 6;
    if (Busy !== 1'b0)      begin failures++; $display("FAIL clr_busy: got %b expected 0", Busy); end
    if (Done !== 1'b0)      begin failures++; $display("FAIL clr_done: got %b expected 0", Done); end
    if (Div_Zero !== 1'b0)  begin failures++; $display("FAIL clr_divzero: got %b expected 0", Div_Zero); end
    if (Write_Reg !== 1'b0) begin failures++; $display("FAIL clr_write: got %b expected 0", Write_Reg); end
    if (W_Addr !== 4'h0)    begin failures++; $display("FAIL clr_waddr: got %h expected 0", W_Addr); end
    if (W_Data !== 32'h0)   begin failures++; $display("FAIL clr_wdata: got %h expected 0", W_Data); end
    @(posedge Clk); #1;
    Clr = 1'b0;
    seen = 0;
    for (int n = 0; n < 45; n++) begin
      @(posedge Clk); #1;
      if (Write_Reg) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL clr_no_write: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_start_busy_ignored();
    int c, extra;
    c = -1;
    issue(2'b10, 1'b0, 32'd100, 32'd7, 4'd2);
    for (int n = 1; n <= 60; n++) begin
      @(posedge Clk); #1;
      if (n == 1) Start = 1'b0;
      if (n == 5) issue(2'b00, 1'b0, 32'd3, 32'd3, 4'd7);
      if (n == 6) Start = 1'b0;
      if (Done) begin
        c = n;
        break;
      end
    end
    checks += 3;
    if (c !== 33)          begin failures++; $display("FAIL ign_latency: got %0d expected 33", c); end
    if (W_Data !== 32'd14) begin failures++; $display("FAIL ign_wdata: got %h expected e", W_Data); end
    if (W_Addr !== 4'd2)   begin failures++; $display("FAIL ign_waddr: got %h expected 2", W_Addr); end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge Clk); #1;
      if (Done) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL ign_no_queue: got %0d extra results expected 0", extra); end
  endtask

  task automatic test_signed();
    int c, bc;
    logic [SIZE:1] exp_q, exp_r, exp_h;
`ifdef MULDIV_SIGNED_EN
    exp_q = 32'hFFFFFFFD; exp_r = 32'hFFFFFFFF; exp_h = 32'hFFFFFFFF;
`else
    exp_q = 32'h7FFFFFFC; exp_r = 32'h00000001; exp_h = 32'h00000001;
`endif
    issue(2'b10, 1'b1, 32'hFFFFFFF9, 32'd2, 4'd8);
    wait_done(c, bc);
    checks += 2;
    if (c !== 33)          begin failures++; $display("FAIL sgn_latency: got %0d expected 33", c); end
    if (W_Data !== exp_q)  begin failures++; $display("FAIL sgn_divq: got %h expected %h", W_Data, exp_q); end
    idle_edge();
    issue(2'b11, 1'b1, 32'hFFFFFFF9, 32'd2, 4'd8);
    wait_done(c, bc);
    checks++;
    if (W_Data !== exp_r)  begin failures++; $display("FAIL sgn_divr: got %h expected %h", W_Data, exp_r); end
    idle_edge();
    issue(2'b01, 1'b1, 32'hFFFFFFFF, 32'd2, 4'd8);
    wait_done(c, bc);
    checks++;
    if (W_Data !== exp_h)  begin failures++; $display("FAIL sgn_mulhi: got %h expected %h", W_Data, exp_h); end
    idle_edge();
  endtask

  initial begin
    test_reset();
    test_mullo();
    test_back_to_back();
    test_div_zero();
    test_div();
    test_clr_abort();
    test_start_busy_ignored();
    test_signed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
